// File: rtl/mem_store_unit.sv
// MEM-stage store unit: checks store alignment, then issues one SB/SH/SW write on the data bus.
// Stalls the pipeline from accept until the bus reports write completion; one-cycle done pulse after.
module mem_store_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        validM,
  input  logic        flushM,
  input  logic [5:0]  op,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic        AdESM,
  output logic [31:0] badvaddrM,
  output logic        stallM,
  output logic        store_doneM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, next_state;
  logic        is_sw, is_sh, is_sb, is_store, accept;
  logic [1:0]  size_c;
  logic [31:0] wdata_c;
  logic [3:0]  wstrb_c;

  assign is_sw    = (op == OP_SW);
  assign is_sh    = (op == OP_SH);
  assign is_sb    = (op == OP_SB);
  assign is_store = is_sw | is_sh | is_sb;

  assign AdESM     = validM & ((is_sw & (aluoutM[1:0] != 2'b00)) | (is_sh & aluoutM[0]));
  assign badvaddrM = AdESM ? aluoutM : 32'h0;

  // DONE deliberately refuses a new store so the pipeline sees the done pulse first
  assign accept = (state == IDLE) & validM & is_store & ~AdESM & ~flushM;

  // Store data is lane-replicated so the slave can pick bytes using the strobe alone
  always_comb begin
    size_c  = 2'b00;
    wdata_c = 32'h0;
    wstrb_c = 4'b0000;
    if (is_sb) begin
      size_c  = 2'b00;
      wdata_c = {4{writedataM[7:0]}};
      wstrb_c = 4'b0001 << aluoutM[1:0];
    end else if (is_sh) begin
      size_c  = 2'b01;
      wdata_c = {2{writedataM[15:0]}};
      wstrb_c = aluoutM[1] ? 4'b1100 : 4'b0011;
    end else if (is_sw) begin
      size_c  = 2'b10;
      wdata_c = writedataM;
      wstrb_c = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    stallM     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = REQ;
          stallM     = 1'b1;
        end
      end
      REQ: begin
        stallM = 1'b1;
        if (data_addr_ok) next_state = data_data_ok ? DONE : WAIT;
      end
      WAIT: begin
        stallM = 1'b1;
        if (data_data_ok) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus outputs are registered; request fields stay frozen from accept until the address handshake
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_req    <= 1'b0;
      data_wr     <= 1'b0;
      data_size   <= 2'b00;
      data_addr   <= 32'h0;
      data_wdata  <= 32'h0;
      data_wstrb  <= 4'b0000;
      store_doneM <= 1'b0;
    end else begin
      data_req    <= (next_state == REQ);
      data_wr     <= (next_state == REQ);
      store_doneM <= (next_state == DONE);
      if (accept) begin
        data_addr  <= {aluoutM[31:2], 2'b00};
        data_wdata <= wdata_c;
        data_size  <= size_c;
        data_wstrb <= wstrb_c;
      end else if (next_state != REQ) begin
        data_wstrb <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_mem_store_unit.sv
// Bench for mem_store_unit: directed vector table, hand-built multi-cycle sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_mem_store_unit;

  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_LW = 6'b100011;

  logic        clk = 1'b0;
  logic        resetn, validM, flushM;
  logic [5:0]  op;
  logic [31:0] aluoutM, writedataM;
  logic        AdESM, stallM, store_doneM;
  logic [31:0] badvaddrM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  int checks   = 0;
  int failures = 0;

  mem_store_unit dut (
    .clk(clk), .resetn(resetn), .validM(validM), .flushM(flushM), .op(op),
    .aluoutM(aluoutM), .writedataM(writedataM), .AdESM(AdESM), .badvaddrM(badvaddrM),
    .stallM(stallM), .store_doneM(store_doneM), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        fault;
    logic        acc;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [3:0]  estrb;
    logic [1:0]  esize;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    validM = 1'b0; flushM = 1'b0; op = 6'd0; aluoutM = 32'h0; writedataM = 32'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  // One store offered for a single cycle; the slave answers addr_ok and data_ok together
  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    idle_inputs();
    validM = 1'b1; op = v.op; aluoutM = v.addr; writedataM = v.wd;
    #1;
    chk({tag, "_AdESM"}, AdESM, v.fault);
    chk({tag, "_badvaddr"}, badvaddrM, v.fault ? v.addr : 32'h0);
    chk({tag, "_stall_accept"}, stallM, v.acc);
    @(negedge clk);
    idle_inputs();
    #1;
    chk({tag, "_req"}, data_req, v.acc);
    if (v.acc) begin
      chk({tag, "_addr"}, data_addr, v.eaddr);
      chk({tag, "_wdata"}, data_wdata, v.ewdata);
      chk({tag, "_wstrb"}, data_wstrb, v.estrb);
      chk({tag, "_size"}, data_size, v.esize);
      chk({tag, "_wr"}, data_wr, 1'b1);
      chk({tag, "_stall_req"}, stallM, 1'b1);
      data_addr_ok = 1'b1; data_data_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      #1;
      chk({tag, "_done"}, store_doneM, 1'b1);
      chk({tag, "_stall_done"}, stallM, 1'b0);
      chk({tag, "_req_done"}, data_req, 1'b0);
      chk({tag, "_wstrb_done"}, data_wstrb, 4'b0000);
    end
    @(negedge clk);
    #1;
    chk({tag, "_done_clear"}, store_doneM, 1'b0);
    chk({tag, "_req_clear"}, data_req, 1'b0);
  endtask

  // Expected bus transaction derived from access width and byte offset
  task automatic txn_of(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] ea, output logic [31:0] ew,
                        output logic [3:0] es, output logic [1:0] sz);
    int nbytes;
    nbytes = (o == OP_SB) ? 1 : (o == OP_SH) ? 2 : 4;
    ea = a - (a % 4);
    if (nbytes == 1)      ew = (d & 32'hFF) * 32'h0101_0101;
    else if (nbytes == 2) ew = (d & 32'hFFFF) * 32'h0001_0001;
    else                  ew = d;
    es = 4'(((1 << nbytes) - 1) << (a % 4));
    sz = 2'($clog2(nbytes));
  endtask

  logic        m_busy, m_addr_taken, m_done;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_strb;
  logic [1:0]  m_size;
  logic        is_store, fault, acc, issue;

  initial begin
    vecs[0] = '{OP_SB, 32'h1000_0003, 32'h1234_56AB, 1'b0, 1'b1, 32'h1000_0000, 32'hABAB_ABAB, 4'b1000, 2'b00};
    vecs[1] = '{OP_SB, 32'h2000_0001, 32'h0000_00C3, 1'b0, 1'b1, 32'h2000_0000, 32'hC3C3_C3C3, 4'b0010, 2'b00};
    vecs[2] = '{OP_SH, 32'h0000_0006, 32'h0000_BEEF, 1'b0, 1'b1, 32'h0000_0004, 32'hBEEF_BEEF, 4'b1100, 2'b01};
    vecs[3] = '{OP_SH, 32'h0000_0104, 32'hFFFF_1234, 1'b0, 1'b1, 32'h0000_0104, 32'h1234_1234, 4'b0011, 2'b01};
    vecs[4] = '{OP_SH, 32'h0000_0005, 32'h0000_1111, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 2'b00};
    vecs[5] = '{OP_SW, 32'h8000_0002, 32'h2222_2222, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 2'b00};
    vecs[6] = '{OP_SW, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 2'b10};
    vecs[7] = '{OP_LW, 32'h0000_0003, 32'h3333_3333, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 2'b00};
    vecs[8] = '{6'b000000, 32'h0000_0010, 32'h4444_4444, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 2'b00};

    // Reset state
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_data_req", data_req, 1'b0);
    chk("rst_data_wr", data_wr, 1'b0);
    chk("rst_data_size", data_size, 2'b00);
    chk("rst_data_addr", data_addr, 32'h0);
    chk("rst_data_wdata", data_wdata, 32'h0);
    chk("rst_data_wstrb", data_wstrb, 4'b0000);
    chk("rst_store_done", store_doneM, 1'b0);
    chk("rst_stallM", stallM, 1'b0);
    chk("rst_AdESM", AdESM, 1'b0);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Address handshake held off for three cycles, then data completes two cycles later
    @(negedge clk);
    idle_inputs();
    validM = 1'b1; op = OP_SW; aluoutM = 32'h8000_0004; writedataM = 32'hCAFE_F00D;
    #1;
    chk("slow_stall_accept", stallM, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      validM = 1'b0;
      #1;
      chk($sformatf("slow_req_hold%0d", k), data_req, 1'b1);
      chk($sformatf("slow_addr_hold%0d", k), data_addr, 32'h8000_0004);
      chk($sformatf("slow_wdata_hold%0d", k), data_wdata, 32'hCAFE_F00D);
      chk($sformatf("slow_stall_hold%0d", k), stallM, 1'b1);
    end
    @(negedge clk);
    data_addr_ok = 1'b1;
    #1;
    chk("slow_req_addr_ok", data_req, 1'b1);
    @(negedge clk);
    data_addr_ok = 1'b0;
    #1;
    chk("slow_wait_req", data_req, 1'b0);
    chk("slow_wait_wstrb", data_wstrb, 4'b0000);
    chk("slow_wait_stall", stallM, 1'b1);
    @(negedge clk);
    data_data_ok = 1'b1;
    #1;
    chk("slow_wait2_stall", stallM, 1'b1);
    @(negedge clk);
    data_data_ok = 1'b0;
    #1;
    chk("slow_done", store_doneM, 1'b1);
    chk("slow_done_stall", stallM, 1'b0);
    @(negedge clk);
    #1;
    chk("slow_idle_done", store_doneM, 1'b0);

    // Flush during WAIT does not cancel the issued write
    @(negedge clk);
    idle_inputs();
    validM = 1'b1; op = OP_SW; aluoutM = 32'h0000_0040; writedataM = 32'h1;
    #1;
    @(negedge clk);
    data_addr_ok = 1'b1;
    #1;
    chk("flw_req", data_req, 1'b1);
    @(negedge clk);
    data_addr_ok = 1'b0; flushM = 1'b1;
    #1;
    chk("flw_wait_stall", stallM, 1'b1);
    @(negedge clk);
    data_data_ok = 1'b1;
    #1;
    chk("flw_wait_req", data_req, 1'b0);
    @(negedge clk);
    data_data_ok = 1'b0;
    #1;
    chk("flw_done", store_doneM, 1'b1);
    @(negedge clk);
    #1;
    chk("flw_done_once", store_doneM, 1'b0);
    chk("flw_no_accept_stall", stallM, 1'b0);
    @(negedge clk);
    #1;
    chk("flw_no_req", data_req, 1'b0);

    // Flush on the accept cycle blocks the store
    @(negedge clk);
    idle_inputs();
    validM = 1'b1; op = OP_SW; aluoutM = 32'h0000_0100; flushM = 1'b1;
    #1;
    chk("fla_stall", stallM, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("fla_req", data_req, 1'b0);

    // Reset while waiting for write completion
    @(negedge clk);
    idle_inputs();
    validM = 1'b1; op = OP_SW; aluoutM = 32'h0000_0200; writedataM = 32'h55;
    #1;
    @(negedge clk);
    validM = 1'b0; data_addr_ok = 1'b1;
    #1;
    @(negedge clk);
    data_addr_ok = 1'b0; resetn = 1'b0;
    #1;
    chk("rw_wait_stall", stallM, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rw_req", data_req, 1'b0);
    chk("rw_stall", stallM, 1'b0);
    chk("rw_done", store_doneM, 1'b0);
    chk("rw_addr", data_addr, 32'h0);
    apply_vec(vecs[6], "rw_after");

    // Randomized traffic against the reference model
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    m_busy = 1'b0; m_addr_taken = 1'b0; m_done = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; m_strb = 4'h0; m_size = 2'b00;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      resetn = ($urandom_range(0, 63) != 0);
      validM = ($urandom_range(0, 9) < 7);
      flushM = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0:       op = OP_SW;
        1:       op = OP_SH;
        2:       op = OP_SB;
        3:       op = OP_LW;
        default: op = 6'($urandom);
      endcase
      aluoutM      = $urandom;
      writedataM   = $urandom;
      data_addr_ok = ($urandom_range(0, 2) == 0);
      data_data_ok = ($urandom_range(0, 2) == 0);
      #1;
      is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
      fault    = validM && (((op == OP_SW) && (aluoutM % 4 != 0)) || ((op == OP_SH) && (aluoutM % 2 != 0)));
      acc      = !m_busy && !m_done && validM && is_store && !fault && !flushM;
      issue    = m_busy && !m_addr_taken;
      chk("rnd_AdESM", AdESM, fault);
      chk("rnd_badvaddr", badvaddrM, fault ? aluoutM : 32'h0);
      chk("rnd_stallM", stallM, acc || m_busy);
      chk("rnd_data_req", data_req, issue);
      chk("rnd_store_done", store_doneM, m_done);
      chk("rnd_wstrb", data_wstrb, issue ? m_strb : 4'b0000);
      if (issue) begin
        chk("rnd_addr", data_addr, m_addr);
        chk("rnd_wdata", data_wdata, m_wdata);
        chk("rnd_size", data_size, m_size);
        chk("rnd_wr", data_wr, 1'b1);
      end
      if (!resetn) begin
        m_busy = 1'b0; m_addr_taken = 1'b0; m_done = 1'b0;
      end else begin
        m_done = m_busy && (m_addr_taken ? data_data_ok : (data_addr_ok && data_data_ok));
        if (m_done)                        m_busy = 1'b0;
        else if (m_busy && data_addr_ok)   m_addr_taken = 1'b1;
        if (acc) begin
          m_busy = 1'b1;
          m_addr_taken = 1'b0;
          txn_of(op, aluoutM, writedataM, m_addr, m_wdata, m_strb, m_size);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_store_unit.md
MEM_STORE_UNIT -- requirements
Module: mem_store_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: resetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: validM  in  1  MEM-stage instruction valid; flushM  in  1  MEM-stage flush.
REQ-004 SHALL have ports: op  in  6  opcode; aluoutM  in  32  effective address; writedataM  in  32  rt store data.
REQ-005 SHALL have ports: AdESM  out  1  store address-error exception; badvaddrM  out  32  faulting address.
REQ-006 SHALL have ports: stallM  out  1  hold pipeline; store_doneM  out  1  one-cycle completion pulse.
REQ-007 SHALL have ports: data_req  out  1; data_wr  out  1; data_size  out  2; data_addr  out  32; data_wdata  out  32; data_wstrb  out  4.
REQ-008 SHALL have ports: data_addr_ok  in  1  address accepted; data_data_ok  in  1  write completed.
REQ-009 SHALL recognise SW=101011, SH=101001, SB=101000; every other opcode is a non-store and is ignored.

Function
REQ-010 SHALL drive AdESM combinationally = validM & ((SW & aluoutM[1:0]!=00) | (SH & aluoutM[0]!=0)); SB never faults.
REQ-011 SHALL drive badvaddrM = aluoutM when AdESM=1, else 32'h0.
REQ-012 SHALL use FSM states IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-013 SHALL "accept" in IDLE when validM & store op & !AdESM & !flushM; on accept capture address, data, strobe and size into registers and move to REQ.
REQ-014 SHALL, in REQ, hold data_req=1 and data_wr=1 with registered outputs constant until data_addr_ok=1.
REQ-015 SHALL, in REQ, go to DONE if data_addr_ok & data_data_ok in the same cycle, to WAIT if data_addr_ok alone, else stay in REQ.
REQ-016 SHALL, in WAIT, keep data_req=0 and go to DONE on data_data_ok, else stay in WAIT (no timeout).
REQ-017 SHALL, in DONE, pulse store_doneM=1 for exactly one cycle, deassert stallM, return to IDLE and not accept that cycle.
REQ-018 SHALL drive stallM=1 combinationally in IDLE on the accept cycle, and in REQ and WAIT; 0 otherwise.
REQ-019 SHALL register data_addr = {aluoutM[31:2],2'b00}.
REQ-020 SHALL, for SB, set size=00, wdata = writedataM[7:0] replicated x4, wstrb = 4'b0001 << aluoutM[1:0].
REQ-021 SHALL, for SH, set size=01, wdata = writedataM[15:0] replicated x2, wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1).
REQ-022 SHALL, for SW, set size=10, wdata=writedataM, wstrb=1111.
REQ-023 SHALL ignore flushM once accepted (REQ/WAIT/DONE); an issued request always completes.
REQ-024 SHALL never accept a faulting store: AdESM=1 gives no data_req, no stall, no store_doneM.
REQ-025 SHALL hold data_req=0 and data_wstrb=0000 outside REQ.
REQ-026 SHALL ignore data_addr_ok/data_data_ok in IDLE and DONE.

Reset
REQ-027 SHALL, on resetn=0 at a rising edge, enter IDLE and clear all registered outputs: data_req=0, data_wr=0, data_size=00, data_addr=0, data_wdata=0, data_wstrb=0000, store_doneM=0.
REQ-028 SHALL abandon any in-flight request on reset (including mid-REQ/WAIT) with data_req=0 in the first post-reset cycle.

Verification
REQ-029 SB addr 0x1000_0003, data 0x1234_56AB, addr_ok/data_ok same cycle -> data_addr 0x1000_0000, wdata 0xABABABAB, wstrb 1000, size 00; stall 2 cycles; store_doneM one pulse.
REQ-030 SH addr 0x0000_0006, data 0x0000_BEEF -> wdata 0xBEEFBEEF, wstrb 1100, size 01; SH addr 0x...05 -> AdESM=1, badvaddrM=0x0000_0005, no data_req.
REQ-031 SW addr 0x8000_0002 -> AdESM=1, stallM=0; SW addr 0x8000_0004, addr_ok delayed 3 cycles -> data_req held 3 cycles with stable addr/wdata; data_ok 2 cycles later -> DONE, then IDLE.
REQ-032 Accept SW, then flushM=1 in WAIT -> request still completes, store_doneM pulses once; flushM=1 on accept cycle -> no request.
REQ-033 resetn=0 while in WAIT -> next cycle IDLE, data_req=0, stallM=0; following SW completes normally.
REQ-034 LW opcode (100011) with misaligned address -> AdESM=0, no request, no stall.
